// File: rtl/dm_pkg.sv
// Shared types and defaults for the data-memory arbiter slice.
// Holds the command struct, the FSM state encoding and the address range check.
package dm_pkg;

  localparam int unsigned DM_AWIDTH  = 32;
  localparam int unsigned DM_ALENGTH = 128;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } dm_arb_state_t;

  typedef struct packed {
    logic                 we;
    logic [DM_AWIDTH-1:0] addr;
    logic [DM_AWIDTH-1:0] wdata;
    logic                 id;
  } dm_cmd_t;

  // Unsigned full-width compare, so huge addresses never alias into range.
  function automatic logic dm_in_range(input logic [DM_AWIDTH-1:0] addr,
                                       input int unsigned alength);
    return (addr < DM_AWIDTH'(alength));
  endfunction

endpackage

// File: rtl/dm_arbiter_if.sv
// Requester and DM-side signal bundle for dm_arbiter.
// The slave modport is the arbiter view; master is the requester/memory view.
interface dm_arbiter_if;
  import dm_pkg::*;

  logic                 p0_req, p1_req;
  logic                 p0_we, p1_we;
  logic [DM_AWIDTH-1:0] p0_addr, p1_addr;
  logic [DM_AWIDTH-1:0] p0_wdata, p1_wdata;
  logic                 p0_gnt, p1_gnt;
  logic                 p0_rvalid, p1_rvalid;
  logic [DM_AWIDTH-1:0] p0_rdata, p1_rdata;
  logic                 p0_err, p1_err;
  logic                 dm_we2;
  logic [DM_AWIDTH-1:0] dm_addr;
  logic [DM_AWIDTH-1:0] dm_wridat;
  logic                 dm_ms2;
  logic [DM_AWIDTH-1:0] dm_wd;

  modport slave (
    input  p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr, p0_wdata, p1_wdata, dm_wd,
    output p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_rdata, p1_rdata, p0_err, p1_err,
           dm_we2, dm_addr, dm_wridat, dm_ms2
  );

  modport master (
    output p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr, p0_wdata, p1_wdata, dm_wd,
    input  p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_rdata, p1_rdata, p0_err, p1_err,
           dm_we2, dm_addr, dm_wridat, dm_ms2
  );

endinterface

// File: rtl/dm_arb_pick.sv
// Two-way request pick. With DM_ARB_ROUND_ROBIN_EN the port not served last
// wins a tie; otherwise port 0 has fixed priority and no pointer exists.
module dm_arb_pick (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req0_i,
  input  logic req1_i,
  input  logic take_i,
  output logic any_o,
  output logic id_o
);

  assign any_o = req0_i | req1_i;

`ifdef DM_ARB_ROUND_ROBIN_EN
  // last_q = 1 means port 1 was served last, so port 0 wins the next tie.
  logic last_q, last_d;

  always_comb begin
    id_o = 1'b0;
    if (req0_i && req1_i) begin
      id_o = ~last_q;
    end else if (req1_i) begin
      id_o = 1'b1;
    end else begin
      id_o = 1'b0;
    end
  end

  always_comb begin
    last_d = last_q;
    if (take_i) begin
      last_d = id_o;
    end else begin
      last_d = last_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`else
  logic unused_s;
  assign unused_s = ^{clk_i, rst_i, take_i};
  assign id_o     = req1_i & ~req0_i;
`endif

endmodule

// File: rtl/dm_arbiter.sv
// Shares the single DM port between the load/store stage (port 0) and the
// loader/debug port (port 1). Tie policy selected by DM_ARB_ROUND_ROBIN_EN.
module dm_arbiter
  import dm_pkg::*;
#(
  parameter int unsigned ALENGTH = DM_ALENGTH
) (
  input logic          clk,
  input logic          rst,
  dm_arbiter_if.slave  bus
);

  dm_arb_state_t        state_q, state_d;
  dm_cmd_t              cmd_q, cmd_d;
  logic                 p0_rvalid_q, p0_rvalid_d, p1_rvalid_q, p1_rvalid_d;
  logic                 p0_err_q, p0_err_d, p1_err_q, p1_err_d;
  logic [DM_AWIDTH-1:0] p0_rdata_q, p0_rdata_d, p1_rdata_q, p1_rdata_d;
  logic                 any_s, win_s, take_s, in_range_s;
  logic                 p0_gnt_s, p1_gnt_s, dm_we2_s, dm_ms2_s;
  logic [DM_AWIDTH-1:0] dm_addr_s, dm_wridat_s, resp_s;

  assign take_s     = any_s && (state_q != ACCESS);
  assign in_range_s = dm_in_range(cmd_q.addr, ALENGTH);
  assign resp_s     = !in_range_s ? '0 : (cmd_q.we ? cmd_q.wdata : bus.dm_wd);

  dm_arb_pick u_pick (
    .clk_i  (clk),
    .rst_i  (rst),
    .req0_i (bus.p0_req),
    .req1_i (bus.p1_req),
    .take_i (take_s),
    .any_o  (any_s),
    .id_o   (win_s)
  );

  // Next state, command latch, DM drive and response capture.
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    p0_rvalid_d = 1'b0;
    p1_rvalid_d = 1'b0;
    p0_rdata_d  = p0_rdata_q;
    p1_rdata_d  = p1_rdata_q;
    p0_err_d    = p0_err_q;
    p1_err_d    = p1_err_q;
    p0_gnt_s    = 1'b0;
    p1_gnt_s    = 1'b0;
    dm_we2_s    = 1'b0;
    dm_ms2_s    = 1'b0;
    dm_addr_s   = '0;
    dm_wridat_s = '0;
    case (state_q)
      IDLE, RESP: begin
        if (take_s) begin
          state_d = ACCESS;
          if (win_s) begin
            p1_gnt_s = 1'b1;
            cmd_d    = '{we: bus.p1_we, addr: bus.p1_addr, wdata: bus.p1_wdata, id: 1'b1};
          end else begin
            p0_gnt_s = 1'b1;
            cmd_d    = '{we: bus.p0_we, addr: bus.p0_addr, wdata: bus.p0_wdata, id: 1'b0};
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        dm_addr_s   = cmd_q.addr;
        dm_wridat_s = cmd_q.wdata;
        dm_ms2_s    = 1'b1;
        dm_we2_s    = cmd_q.we & in_range_s;
        state_d     = RESP;
        if (cmd_q.id) begin
          p1_rvalid_d = 1'b1;
          p1_rdata_d  = resp_s;
          p1_err_d    = ~in_range_s;
        end else begin
          p0_rvalid_d = 1'b1;
          p0_rdata_d  = resp_s;
          p0_err_d    = ~in_range_s;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and response registers; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      p0_rvalid_q <= 1'b0;
      p1_rvalid_q <= 1'b0;
      p0_rdata_q  <= '0;
      p1_rdata_q  <= '0;
      p0_err_q    <= 1'b0;
      p1_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      p0_rvalid_q <= p0_rvalid_d;
      p1_rvalid_q <= p1_rvalid_d;
      p0_rdata_q  <= p0_rdata_d;
      p1_rdata_q  <= p1_rdata_d;
      p0_err_q    <= p0_err_d;
      p1_err_q    <= p1_err_d;
    end
  end

  assign bus.p0_gnt    = p0_gnt_s;
  assign bus.p1_gnt    = p1_gnt_s;
  assign bus.p0_rvalid = p0_rvalid_q;
  assign bus.p1_rvalid = p1_rvalid_q;
  assign bus.p0_rdata  = p0_rdata_q;
  assign bus.p1_rdata  = p1_rdata_q;
  assign bus.p0_err    = p0_err_q;
  assign bus.p1_err    = p1_err_q;
  assign bus.dm_we2    = dm_we2_s;
  assign bus.dm_ms2    = dm_ms2_s;
  assign bus.dm_addr   = dm_addr_s;
  assign bus.dm_wridat = dm_wridat_s;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a behavioural 128-word DM model.
// Tie-break expectations follow DM_ARB_ROUND_ROBIN_EN.
module tb_dm_arbiter;
  import dm_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic load_mem;
  int   err_cnt;
  int   chk_cnt;
  int   we2_cnt;
  logic [31:0] mem [0:127];
  int   win [0:3];

  always #5 clk = ~clk;

  dm_arbiter_if bus ();

  dm_arbiter #(.ALENGTH(DM_ALENGTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.dm_wd = (bus.dm_addr < 32'd128) ? mem[bus.dm_addr[6:0]] : 32'd0;

  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < 128; i++) mem[i] <= 32'hA500_0000 | 32'(i);
      we2_cnt <= 0;
    end else if (bus.dm_we2) begin
      mem[bus.dm_addr[6:0]] <= bus.dm_wridat;
      we2_cnt <= we2_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int port, input logic req, input logic we,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (port == 0) begin
      bus.p0_req = req; bus.p0_we = we; bus.p0_addr = addr; bus.p0_wdata = wdata;
    end else begin
      bus.p1_req = req; bus.p1_we = we; bus.p1_addr = addr; bus.p1_wdata = wdata;
    end
  endtask

  initial begin
    err_cnt = 0;
    chk_cnt = 0;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
    rst = 1'b1;
    load_mem = 1'b1;
    repeat (3) @(negedge clk);
    load_mem = 1'b0;
    rst = 1'b0;
    #1;
    check("rst_gnt", {30'd0, bus.p1_gnt, bus.p0_gnt}, 32'd0);
    check("rst_rvalid", {30'd0, bus.p1_rvalid, bus.p0_rvalid}, 32'd0);
    check("rst_err", {30'd0, bus.p1_err, bus.p0_err}, 32'd0);
    check("rst_p0_rdata", bus.p0_rdata, 32'd0);
    check("rst_p1_rdata", bus.p1_rdata, 32'd0);
    check("rst_dm_ctl", {30'd0, bus.dm_we2, bus.dm_ms2}, 32'd0);
    check("rst_dm_addr", bus.dm_addr, 32'd0);
    check("rst_dm_wridat", bus.dm_wridat, 32'd0);
    repeat (20) @(negedge clk);
    #1;
    check("idle_we2_cnt", 32'(we2_cnt), 32'd0);
    check("idle_rvalid", {30'd0, bus.p1_rvalid, bus.p0_rvalid}, 32'd0);

    // P0 write 0x6000 to 0x37, then read it back.
    @(negedge clk); drive(0, 1'b1, 1'b1, 32'h37, 32'h0000_6000); #1;
    check("wr_p0_gnt", {31'd0, bus.p0_gnt}, 32'd1);
    @(negedge clk); drive(0, 1'b0, 1'b0, 32'd0, 32'd0); #1;
    check("wr_acc_we2", {31'd0, bus.dm_we2}, 32'd1);
    check("wr_acc_ms2", {31'd0, bus.dm_ms2}, 32'd1);
    check("wr_acc_addr", bus.dm_addr, 32'h37);
    check("wr_acc_wridat", bus.dm_wridat, 32'h0000_6000);
    @(negedge clk); drive(0, 1'b1, 1'b0, 32'h37, 32'd0); #1;
    check("wr_rvalid", {31'd0, bus.p0_rvalid}, 32'd1);
    check("wr_rdata", bus.p0_rdata, 32'h0000_6000);
    check("wr_resp_we2", {31'd0, bus.dm_we2}, 32'd0);
    check("rd_p0_gnt", {31'd0, bus.p0_gnt}, 32'd1);
    @(negedge clk); drive(0, 1'b0, 1'b0, 32'd0, 32'd0); #1;
    check("rd_acc_we2", {31'd0, bus.dm_we2}, 32'd0);
    check("rd_acc_ms2", {31'd0, bus.dm_ms2}, 32'd1);
    check("rd_no_rvalid", {31'd0, bus.p0_rvalid}, 32'd0);
    @(negedge clk); #1;
    check("rd_rvalid", {31'd0, bus.p0_rvalid}, 32'd1);
    check("rd_rdata", bus.p0_rdata, 32'h0000_6000);
    check("rd_err", {31'd0, bus.p0_err}, 32'd0);
    check("wr_we2_once", 32'(we2_cnt), 32'd1);
    @(negedge clk); #1;
    check("rd_rvalid_pulse", {31'd0, bus.p0_rvalid}, 32'd0);

    // P1 write far out of range.
    @(negedge clk); drive(1, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hDEAD_BEEF); #1;
    check("oor_p1_gnt", {30'd0, bus.p1_gnt, bus.p0_gnt}, 32'd2);
    @(negedge clk); drive(1, 1'b0, 1'b0, 32'd0, 32'd0); #1;
    check("oor_we2", {31'd0, bus.dm_we2}, 32'd0);
    check("oor_addr", bus.dm_addr, 32'hFFFF_FFFF);
    @(negedge clk); #1;
    check("oor_rvalid", {30'd0, bus.p1_rvalid, bus.p0_rvalid}, 32'd2);
    check("oor_err", {31'd0, bus.p1_err}, 32'd1);
    check("oor_rdata", bus.p1_rdata, 32'd0);
    check("oor_p0_held", bus.p0_rdata, 32'h0000_6000);
    check("oor_we2_cnt", 32'(we2_cnt), 32'd1);
    check("oor_mem0", mem[0], 32'hA500_0000);
    check("oor_mem37", mem[7'h37], 32'h0000_6000);

    // Both ports request continuously: reads of addr 1 (p0) and 2 (p1).
    for (int k = 0; k < 4; k++) begin
`ifdef DM_ARB_ROUND_ROBIN_EN
      win[k] = k % 2;
`else
      win[k] = 0;
`endif
    end
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if (c == 0) begin
        drive(0, 1'b1, 1'b0, 32'd1, 32'd0);
        drive(1, 1'b1, 1'b0, 32'd2, 32'd0);
      end
      if (c == 7) begin
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
      end
      #1;
      if (c % 2 == 1) begin
        check("both_acc_nognt", {30'd0, bus.p1_gnt, bus.p0_gnt}, 32'd0);
        check("both_acc_ms2", {31'd0, bus.dm_ms2}, 32'd1);
      end else if (c < 8) begin
        check("both_gnt", {30'd0, bus.p1_gnt, bus.p0_gnt}, (win[c/2] == 1) ? 32'd2 : 32'd1);
      end else begin
        check("both_end_nognt", {30'd0, bus.p1_gnt, bus.p0_gnt}, 32'd0);
      end
      if (c >= 2 && c % 2 == 0) begin
        check("both_rvalid", {30'd0, bus.p1_rvalid, bus.p0_rvalid},
              (win[c/2-1] == 1) ? 32'd2 : 32'd1);
        check("both_rdata", (win[c/2-1] == 1) ? bus.p1_rdata : bus.p0_rdata,
              (win[c/2-1] == 1) ? 32'hA500_0002 : 32'hA500_0001);
      end
    end

    // Reset while a write is in ACCESS.
    @(negedge clk); drive(0, 1'b1, 1'b1, 32'd5, 32'h1234_5678); #1;
    check("rst_acc_gnt", {31'd0, bus.p0_gnt}, 32'd1);
    @(negedge clk); drive(0, 1'b0, 1'b0, 32'd0, 32'd0); rst = 1'b1; #1;
    check("rst_acc_we2", {31'd0, bus.dm_we2}, 32'd1);
    @(negedge clk); rst = 1'b0; #1;
    check("rst_acc_rvalid", {30'd0, bus.p1_rvalid, bus.p0_rvalid}, 32'd0);
    check("rst_acc_p0_rdata", bus.p0_rdata, 32'd0);
    check("rst_acc_dm", {30'd0, bus.dm_we2, bus.dm_ms2}, 32'd0);
    check("rst_acc_dm_addr", bus.dm_addr, 32'd0);
    check("rst_acc_mem5", mem[5], 32'h1234_5678);
    drive(1, 1'b1, 1'b0, 32'h37, 32'd0); #1;
    check("post_rst_gnt", {30'd0, bus.p1_gnt, bus.p0_gnt}, 32'd2);
    @(negedge clk); drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk); #1;
    check("post_rst_rvalid", {31'd0, bus.p1_rvalid}, 32'd1);
    check("post_rst_rdata", bus.p1_rdata, 32'h0000_6000);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Two-port arbiter and sequencer for the general data memory (DM). It shares the single DM write/read port between the processor load/store stage (port 0) and the loader/debug port (port 1). It latches one winning request, drives the DM control lines for exactly one access cycle, and returns read data plus an out-of-range error to the winner. It sits between the execute/memory stage and the `DM` instance in the processor top level.

## Interface
- `AWIDTH`, 32, address and data width
- `ALENGTH`, 128, number of DM words; valid addresses are 0..ALENGTH-1

- `clk`  in  1  single clock; all state changes on the rising edge
- `rst`  in  1  reset, synchronous, active-high
- `p0_req`, `p1_req`  in  1  request; held high until the matching gnt
- `p0_we`, `p1_we`  in  1  1 = write, 0 = read
- `p0_addr`, `p1_addr`  in  AWIDTH  word address
- `p0_wdata`, `p1_wdata`  in  AWIDTH  write data
- `p0_gnt`, `p1_gnt`  out  1  one-cycle pulse; the request is accepted on this edge
- `p0_rvalid`, `p1_rvalid`  out  1  one-cycle response pulse
- `p0_rdata`, `p1_rdata`  out  AWIDTH  read data, valid with rvalid
- `p0_err`, `p1_err`  out  1  address out of range, valid with rvalid
- `dm_we2`  out  1  to DM `WE2`
- `dm_addr`  out  AWIDTH  to DM `Addr`
- `dm_wridat`  out  AWIDTH  to DM `WriDat`
- `dm_ms2`  out  1  to DM `MS2`; 1 selects memory data on `WD`
- `dm_wd`  in  AWIDTH  from DM `WD`

## Operation
- FSM states are IDLE, ACCESS and RESP. Reset forces IDLE.
- Reset values: all gnt, rvalid, err and `dm_*` outputs are 0; rdata is 0; round-robin pointer favours port 0.
- **Arbitration** happens in IDLE and in RESP. If any request is pending:
  - assert the winner's gnt for that cycle;
  - latch the winner's id, we, addr and wdata;
  - go to ACCESS.
  - If no request is pending, go to (or stay in) IDLE.
- **ACCESS** (exactly one cycle):
  - `dm_addr` = latched addr; `dm_wridat` = latched wdata; `dm_ms2` = 1.
  - `dm_we2` = latched we AND in_range, where in_range = (addr < ALENGTH) as an unsigned full-width compare.
  - Capture `dm_wd` into the response register; if not in_range, capture 0 instead.
  - Go to RESP.
- **RESP**:
  - Pulse rvalid for the owner only. rdata and err are held until that owner's next rvalid.
  - Writes return rdata = wdata when in range.
  - Arbitrate for the next access in the same cycle (back-to-back).
- Outside ACCESS: `dm_we2` = 0, `dm_ms2` = 0, `dm_addr` = 0, `dm_wridat` = 0.
- An out-of-range access never writes. It still completes with err = 1 and rdata = 0.
- Reset mid-operation: the access is abandoned and no rvalid is issued. A write in ACCESS when reset is sampled is still presented for that cycle.

## Timing
- Request to gnt: 0 cycles when the FSM is in IDLE or RESP.
- gnt to ACCESS: 1 cycle. gnt to rvalid: 2 cycles.
- Sustained throughput: one access per 2 cycles (RESP overlaps the next grant).
- Simultaneous requests: exactly one gnt per arbitration cycle. The loser keeps req high and is served at the next arbitration cycle.
- A requester drops or changes req/cmd only after its gnt. Inputs are not sampled in ACCESS.

## Configuration
- `DM_ARB_ROUND_ROBIN_EN` defined: on a simultaneous request, the port not served last wins. The pointer updates on each gnt.
- Not defined: fixed priority, port 0 always wins, and the pointer logic is absent. Port 1 can starve.

## Structure
- Shared package `dm_pkg` holds:
  - the `AWIDTH`/`ALENGTH` defaults;
  - typedef enum `dm_arb_state_t` {IDLE, ACCESS, RESP};
  - packed struct `dm_cmd_t` {we, addr, wdata, id}.
- One sub-module `dm_arb_pick`: combinational 2-way pick with the round-robin pointer register.
- FSM, command latch and response registers live in `dm_arbiter`.

## Test plan
- Reset, then idle: all outputs 0; `dm_we2` never asserted over 20 cycles.
- P0 write 0x00006000 to 0x37, then P0 read 0x37: `dm_we2` high for exactly one cycle; read rvalid 2 cycles after gnt with rdata = 0x00006000, err = 0.
- P1 write to 0xFFFFFFFF: no `dm_we2` pulse; p1_rvalid with err = 1, rdata = 0. MEM[0] and MEM[0x37] are unchanged.
- Both ports request every cycle: with `DM_ARB_ROUND_ROBIN_EN`, grants alternate 0,1,0,1; without it, all grants go to port 0.
- Back-to-back: p0 rvalid and p1 gnt in the same cycle; next ACCESS follows immediately.
- Assert rst during ACCESS: the next cycle is IDLE, no rvalid, all outputs at reset values.
